// File: rtl/small_poly_encode.sv
// small_poly_encode: reads the 757 ternary coefficients left by the small
// polynomial generator, packs them 4 per byte as (coef+1) in 2-bit codes
// (LSB-first), streams the 190 bytes over valid/ready, and reports the
// Hamming weight and any illegal coefficient value.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for start after reset
// S_FETCH | issuing one read per cycle, mapping data of the previous read
// S_DRAIN | mapping the last outstanding read, loading byte_out
// S_EMIT  | holding byte_out/byte_valid until byte_ready
// S_DONE  | pass complete, weight_ok valid, waiting for the next start
module small_poly_encode #(
    parameter int P  = 757,
    parameter int Q  = 5167,
    parameter int W  = 242,
    parameter int AW = 11,
    parameter int DW = 13
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic [AW-1:0] mem_address_o,
    input  logic [DW-1:0] mem_output,
    output logic [7:0]    byte_out,
    output logic          byte_valid,
    input  logic          byte_ready,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] weight,
    output logic          weight_ok,
    output logic          coeff_err
);

    localparam logic [DW-1:0] QM1      = DW'(Q - 1);
    localparam logic [AW-1:0] IDX_END  = AW'(P);
    localparam logic [AW-1:0] IDX_LAST = AW'(P - 1);
    localparam logic [AW-1:0] W_REQ    = AW'(W);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DRAIN,
        S_EMIT,
        S_DONE
    } state_t;

    state_t        r_state;
    logic [AW-1:0] r_addr;
    logic [AW-1:0] r_idx;      // number of reads issued so far in this pass
    logic [1:0]    r_cnt;      // reads issued for the current byte, minus one
    logic [1:0]    r_pos;      // next 2-bit slot in the pack register
    logic [7:0]    r_pack;
    logic [7:0]    r_byte;
    logic          r_valid;
    logic          r_busy;
    logic          r_done;
    logic [AW-1:0] r_weight;
    logic          r_ok;
    logic          r_err;

    logic [1:0]    w_code;
    logic          w_nz;
    logic          w_bad;
    logic          w_capture;
    logic [7:0]    w_full;

    // Map the returned coefficient to its 2-bit code and classify it.
    always_comb begin
        w_code = 2'b01;
        w_nz   = 1'b0;
        w_bad  = 1'b0;
        if (mem_output == '0) begin
            w_code = 2'b01;
        end else if (mem_output == DW'(1)) begin
            w_code = 2'b10;
            w_nz   = 1'b1;
        end else if (mem_output == QM1) begin
            w_code = 2'b00;
            w_nz   = 1'b1;
        end else begin
            w_bad  = 1'b1;
        end
    end

    // Read data is live on every FETCH cycle except the first of a byte, and in DRAIN.
    always_comb begin
        w_capture = ((r_state == S_FETCH) && (r_cnt != 2'd0)) || (r_state == S_DRAIN);
        w_full    = r_pack;
        w_full[{r_pos, 1'b0} +: 2] = w_code;
    end

    // Sequencer: address generation, packing, weight/error tracking and handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_addr   <= '0;
            r_idx    <= '0;
            r_cnt    <= '0;
            r_pos    <= '0;
            r_pack   <= '0;
            r_byte   <= '0;
            r_valid  <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_weight <= '0;
            r_ok     <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            if (w_capture) begin
                r_pack[{r_pos, 1'b0} +: 2] <= w_code;
                r_pos <= r_pos + 2'd1;
                if (w_nz)  r_weight <= r_weight + 1'b1;
                if (w_bad) r_err    <= 1'b1;
            end
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_weight <= '0;
                        r_err    <= 1'b0;
                        r_ok     <= 1'b0;
                        r_done   <= 1'b0;
                        r_busy   <= 1'b1;
                        r_idx    <= '0;
                        r_addr   <= '0;
                        r_cnt    <= '0;
                        r_pos    <= '0;
                        r_pack   <= '0;
                        r_state  <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    r_idx <= r_idx + 1'b1;
                    // The final byte carries a single coefficient, so it ends after one read.
                    if ((r_cnt == 2'd3) || (r_idx == IDX_LAST)) begin
                        r_state <= S_DRAIN;
                    end else begin
                        r_addr <= r_addr + 1'b1;
                        r_cnt  <= r_cnt + 2'd1;
                    end
                end
                S_DRAIN: begin
                    r_byte  <= w_full;
                    r_valid <= 1'b1;
                    r_pack  <= '0;
                    r_pos   <= '0;
                    r_cnt   <= '0;
                    r_state <= S_EMIT;
                end
                S_EMIT: begin
                    if (byte_ready) begin
                        r_valid <= 1'b0;
                        if (r_idx == IDX_END) begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_ok    <= (r_weight == W_REQ) && !r_err;
                            r_state <= S_DONE;
                        end else begin
                            r_addr  <= r_idx;
                            r_state <= S_FETCH;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign mem_address_o = r_addr;
    assign byte_out      = r_byte;
    assign byte_valid    = r_valid;
    assign busy          = r_busy;
    assign done          = r_done;
    assign weight        = r_weight;
    assign weight_ok     = r_ok;
    assign coeff_err     = r_err;

endmodule

// File: tb/tb_small_poly_encode.sv
// Testbench for small_poly_encode: directed coefficient patterns, a byte-level
// reference model computed from the memory contents, and a per-cycle checker
// for stream contents, stall stability and address range.
module tb_small_poly_encode;

    localparam int P  = 757;
    localparam int Q  = 5167;
    localparam int W  = 242;
    localparam int AW = 11;
    localparam int DW = 13;
    localparam int NB = 190;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          byte_ready = 1'b0;
    logic [AW-1:0] mem_address_o;
    logic [DW-1:0] mem_output;
    logic [7:0]    byte_out;
    logic          byte_valid;
    logic          busy;
    logic          done;
    logic [AW-1:0] weight;
    logic          weight_ok;
    logic          coeff_err;

    small_poly_encode dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .mem_address_o (mem_address_o),
        .mem_output    (mem_output),
        .byte_out      (byte_out),
        .byte_valid    (byte_valid),
        .byte_ready    (byte_ready),
        .busy          (busy),
        .done          (done),
        .weight        (weight),
        .weight_ok     (weight_ok),
        .coeff_err     (coeff_err)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem [0:P-1];

    // Coefficient memory with one cycle of read latency.
    always @(posedge clk) begin
        if (int'(mem_address_o) < P) mem_output <= mem[mem_address_o];
        else                         mem_output <= '0;
    end

    int n_err = 0;
    int n_chk = 0;
    int hs_cnt = 0;
    int mode = 0;
    int b3_low = 0;
    logic [7:0] exp_bytes [NB];
    int  m_weight;
    bit  m_err;

    task automatic check_eq(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Reference: byte k is the sum of code(mem[4k+j]) << 2j, code = coef+1 over {-1,0,1}.
    task automatic build_model();
        m_weight = 0;
        m_err = 1'b0;
        for (int k = 0; k < NB; k++) begin
            int b;
            b = 0;
            for (int j = 0; j < 4; j++) begin
                int i;
                int c;
                i = 4 * k + j;
                if (i < P) begin
                    if (mem[i] == 0)            c = 1;
                    else if (mem[i] == 1)     begin c = 2; m_weight++; end
                    else if (mem[i] == Q - 1) begin c = 0; m_weight++; end
                    else                      begin c = 1; m_err = 1'b1; end
                    b = b + (c << (2 * j));
                end
            end
            exp_bytes[k] = 8'(b);
        end
    endtask

    // Downstream ready: tied high, or a 10-cycle stall on byte 3 plus random stalls.
    always @(posedge clk) begin
        #2;
        if (mode == 0) begin
            byte_ready = 1'b1;
        end else if (byte_valid && hs_cnt == 3 && b3_low < 10) begin
            byte_ready = 1'b0;
            b3_low++;
        end else begin
            byte_ready = ($urandom_range(0, 3) != 0);
        end
    end

    logic       prev_valid = 1'b0;
    logic       prev_ready = 1'b0;
    logic [7:0] prev_byte = '0;
    logic [AW-1:0] prev_addr = '0;

    // Per-cycle checker: stream contents, stall stability, no reads while stalled.
    always @(negedge clk) begin
        if (rst) begin
            prev_valid = 1'b0;
        end else begin
            check_eq("addr_range", int'(int'(mem_address_o) <= P - 1), 1);
            if (prev_valid && !prev_ready) begin
                check_eq("stall_valid", int'(byte_valid), 1);
                check_eq("stall_byte_hold", int'(byte_out), int'(prev_byte));
                check_eq("stall_no_read", int'(mem_address_o), int'(prev_addr));
            end
            if (byte_valid && byte_ready) begin
                if (hs_cnt < NB) check_eq($sformatf("byte[%0d]", hs_cnt), int'(byte_out), int'(exp_bytes[hs_cnt]));
                else             check_eq("extra_byte", hs_cnt, NB - 1);
                hs_cnt++;
            end
            prev_valid = byte_valid;
            prev_ready = byte_ready;
            prev_byte  = byte_out;
            prev_addr  = mem_address_o;
        end
    end

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic run_pass(input int md, input string tag);
        int lat;
        mode = md;
        b3_low = 0;
        build_model();
        hs_cnt = 0;
        pulse_start();
        check_eq({tag, "_busy_after_start"}, int'(busy), 1);
        check_eq({tag, "_done_after_start"}, int'(done), 0);
        lat = 0;
        for (int c = 1; c <= 8 && lat == 0; c++) begin
            @(posedge clk); #1;
            if (byte_valid) lat = c;
        end
        check_eq({tag, "_first_valid_latency"}, lat, 5);
        for (int c = 0; c < 20000 && !done; c++) begin
            @(posedge clk); #1;
        end
        check_eq({tag, "_done_reached"}, int'(done), 1);
        check_eq({tag, "_handshakes"}, hs_cnt, NB);
        check_eq({tag, "_weight"}, int'(weight), m_weight);
        check_eq({tag, "_coeff_err"}, int'(coeff_err), int'(m_err));
        check_eq({tag, "_weight_ok"}, int'(weight_ok), int'(m_weight == W && !m_err));
        check_eq({tag, "_busy_at_done"}, int'(busy), 0);
        check_eq({tag, "_valid_at_done"}, int'(byte_valid), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_addr"}, int'(mem_address_o), 0);
        check_eq({tag, "_byte_out"}, int'(byte_out), 0);
        check_eq({tag, "_byte_valid"}, int'(byte_valid), 0);
        check_eq({tag, "_busy"}, int'(busy), 0);
        check_eq({tag, "_done"}, int'(done), 0);
        check_eq({tag, "_weight"}, int'(weight), 0);
        check_eq({tag, "_weight_ok"}, int'(weight_ok), 0);
        check_eq({tag, "_coeff_err"}, int'(coeff_err), 0);
    endtask

    task automatic fill_zero();
        for (int i = 0; i < P; i++) mem[i] = '0;
    endtask

    task automatic fill_prefix_ones(input int n);
        for (int i = 0; i < P; i++) mem[i] = (i < n) ? DW'(1) : DW'(0);
    endtask

    task automatic fill_alt();
        for (int i = 0; i < P; i++) begin
            if (i < 484 && i % 4 == 0)      mem[i] = DW'(1);
            else if (i < 484 && i % 4 == 1) mem[i] = DW'(Q - 1);
            else                            mem[i] = DW'(0);
        end
    endtask

    initial begin
        fill_zero();
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;

        // All zero coefficients.
        fill_zero();
        build_model();
        check_eq("t1_model_byte0", int'(exp_bytes[0]), 'h55);
        check_eq("t1_model_byte189", int'(exp_bytes[189]), 'h01);
        run_pass(0, "t1");
        check_eq("t1_weight_lit", int'(weight), 0);
        check_eq("t1_ok_lit", int'(weight_ok), 0);

        // First 242 coefficients equal to 1.
        fill_prefix_ones(242);
        build_model();
        check_eq("t2_model_byte59", int'(exp_bytes[59]), 'hAA);
        check_eq("t2_model_byte60", int'(exp_bytes[60]), 'h5A);
        check_eq("t2_model_byte189", int'(exp_bytes[189]), 'h01);
        run_pass(0, "t2");
        check_eq("t2_weight_lit", int'(weight), 242);
        check_eq("t2_ok_lit", int'(weight_ok), 1);

        // Pattern 1,Q-1,0,0 repeated 121 times.
        fill_alt();
        build_model();
        check_eq("t3_model_byte0", int'(exp_bytes[0]), 'h52);
        run_pass(0, "t3");
        check_eq("t3_weight_lit", int'(weight), 242);
        check_eq("t3_ok_lit", int'(weight_ok), 1);

        // Illegal value 7 at coefficient 5 inside a weight-242 pattern.
        fill_prefix_ones(243);
        mem[5] = DW'(7);
        build_model();
        check_eq("t4_model_byte1", int'(exp_bytes[1]), 'hA6);
        run_pass(0, "t4");
        check_eq("t4_err_lit", int'(coeff_err), 1);
        check_eq("t4_byte1_code", int'(exp_bytes[1][3:2]), 1);
        check_eq("t4_weight_lit", int'(weight), 242);
        check_eq("t4_ok_lit", int'(weight_ok), 0);

        // Same stream as t3 with downstream stalls.
        fill_alt();
        run_pass(1, "t5");
        check_eq("t5_byte3_stall_len", b3_low, 10);
        check_eq("t5_weight_lit", int'(weight), 242);

        // Reset mid-pass at byte 100, then a clean full pass.
        fill_prefix_ones(242);
        mode = 0;
        build_model();
        hs_cnt = 0;
        pulse_start();
        for (int c = 0; c < 2000 && hs_cnt < 100; c++) begin
            @(posedge clk); #1;
        end
        check_eq("t6_reached_byte100", int'(hs_cnt >= 100), 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_reset_outputs("t6_reset");
        run_pass(0, "t6b");
        check_eq("t6_ok_lit", int'(weight_ok), 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/small_poly_encode.md
Name: small_poly_encode

Overview:
- Stage directly downstream of the small (ternary) polynomial generator in the SNTRUP757 key-generation path.
- Reads the P=757 ternary coefficients that the generator left in coefficient memory. Each coefficient is 13-bit, stored as 0, 1 or Q-1 with Q=5167.
- Packs the coefficients 4 per byte, 2 bits each, as (coef+1), giving a 190-byte stream with valid/ready handshake.
- Checks Hamming weight against W and flags illegal coefficient values.

Parameters:
- P, 757, number of coefficients.
- Q, 5167, modulus; the stored value Q-1 represents -1.
- W, 242, required Hamming weight.
- AW, 11, memory address width.
- DW, 13, memory data width.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins an encode pass.
- mem_address_o  out  AW  coefficient memory read address.
- mem_output  in  DW  read data; valid the cycle after the address is presented (1-cycle latency).
- byte_out  out  8  packed byte.
- byte_valid  out  1  byte_out holds a valid byte.
- byte_ready  in  1  downstream accepts the byte when byte_valid && byte_ready.
- busy  out  1  high from start until done.
- done  out  1  level; high in DONE until the next start or rst.
- weight  out  AW  count of nonzero legal coefficients seen.
- weight_ok  out  1  valid while done: (weight==W) && !coeff_err.
- coeff_err  out  1  sticky: some read value was not in {0, 1, Q-1}.

Behaviour:
- Reset (rst=1 at a clk edge, in any state):
  - State goes to IDLE.
  - mem_address_o=0, byte_out=0, byte_valid=0, busy=0, done=0, weight=0, weight_ok=0, coeff_err=0.
  - Any in-flight byte is dropped.
- Coefficient mapping to 2-bit code:
  - 0 -> 2'b01.
  - 1 -> 2'b10; weight increments.
  - Q-1 -> 2'b00; weight increments.
  - Any other value -> 2'b01, sets coeff_err; weight unchanged.
- Byte layout: coefficient 4k+j occupies bits [2j+1:2j] of byte k (LSB-first).
- Final byte (k=189) holds only coefficient 756 in bits [1:0]; bits [7:2]=0.
- States:
  - IDLE: wait for start. On start, clear weight, coeff_err and the coefficient index (idx=0), go to FETCH. busy=1 from the cycle after start.
  - FETCH: present mem_address_o=idx each cycle and increment idx. Data for the address issued in the previous cycle is mapped and shifted into the pack register that same cycle. Leave after 4 issues, or 1 issue for the final byte; go to DRAIN.
  - DRAIN: capture and map the last outstanding read, load byte_out, set byte_valid=1, go to EMIT.
  - EMIT: hold byte_out and byte_valid stable until byte_ready=1.
    - On handshake, clear byte_valid.
    - If idx==P, go to DONE; otherwise go to FETCH.
    - No memory reads are issued in EMIT.
  - DONE: busy=0, done=1; weight_ok is evaluated. start here clears flags and re-enters FETCH with idx=0.
- Timing:
  - A full byte takes 4 FETCH + 1 DRAIN cycles; byte_valid rises 5 cycles after entering FETCH.
  - With byte_ready tied high, throughput is 1 byte per 6 cycles.
  - First byte_valid appears 6 cycles after the start pulse.
- byte_ready asserted while byte_valid=0 is ignored.
- start while busy is ignored.
- weight counter is AW bits wide; the maximum possible value is 757, so it cannot overflow.
- mem_address_o never exceeds P-1; it holds its last value outside FETCH.

Test Plan:
- All coefficients 0, byte_ready=1 → 189 bytes of 0x55, then 0x01; weight=0, weight_ok=0, coeff_err=0, done=1.
- Coefficients 0..241 = 1 and rest 0 → bytes 0..59 = 0xAA, byte 60 = 0x5A, byte 189 = 0x01; weight=242, weight_ok=1.
- 242 nonzero coefficients alternating 1/Q-1 (pattern 1,Q-1,0,0 repeating, 121 groups) → byte 0 = 0x52; weight=242, weight_ok=1; exactly 190 handshakes.
- Coefficient 5 = 7, otherwise a legal weight-242 pattern → coeff_err=1, byte 1 bits[3:2]=01, weight_ok=0 at done.
- byte_ready held low for 10 cycles on byte 3, plus random stalls elsewhere → byte_out stable while stalled, no reads issued during stalls, byte sequence identical to the unstalled run.
- rst asserted mid-pass at byte 100, then start → all outputs at reset values the next cycle; the new pass restarts at address 0 and produces the full 190-byte stream.
